// File: rtl/crc_serial_engine.sv
// Bit-serial CRC division engine: absorbs message bits one per clock, then
// snapshots the remainder and shifts it out MSB-first on request.
module crc_serial_engine #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'h1021,
   parameter logic [WIDTH-1:0] INIT  = 16'h0000,
   parameter int               CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CLEAR,
   input  logic             DATA_IN,
   input  logic             READ_MODE,
   output logic             CRC_OUT,
   output logic [WIDTH-1:0] CRC_VALUE,
   output logic [CNT_W-1:0] BIT_COUNT,
   output logic             FRAME_DONE,
   output logic             CRC_ZERO,
   output logic             OVERRUN
);

   typedef enum logic [1:0] {ACCUM, READOUT, DRAINED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   crc_reg, crc_d, crc_step;
   // The MSB goes straight to CRC_OUT on readout entry, so the shifter only
   // needs to keep the remaining WIDTH-1 bits.
   logic [WIDTH-2:0]   sr, sr_d;
   logic               out_d, done_d, zero_d, overrun_d;
   logic [WIDTH-1:0]   value_d;
   logic [CNT_W-1:0]   count_d, count_inc;

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_reg;
      sr_d      = sr;
      out_d     = CRC_OUT;
      value_d   = CRC_VALUE;
      zero_d    = CRC_ZERO;
      count_d   = BIT_COUNT;
      done_d    = 1'b0;
      overrun_d = OVERRUN;
      crc_step  = {crc_reg[WIDTH-2:0], DATA_IN} ^ (crc_reg[WIDTH-1] ? POLY : '0);
      count_inc = (BIT_COUNT == CNT_MAX) ? BIT_COUNT : BIT_COUNT + CNT_ONE;

      if (CLEAR) begin
         state_d   = ACCUM;
         crc_d     = INIT;
         sr_d      = '0;
         out_d     = 1'b0;
         count_d   = '0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (!READ_MODE) begin
                  crc_d   = crc_step;
                  count_d = count_inc;
                  out_d   = crc_step[WIDTH-1];
               end else begin
                  sr_d    = crc_reg[WIDTH-2:0];
                  value_d = crc_reg;
                  zero_d  = (crc_reg == '0);
                  out_d   = crc_reg[WIDTH-1];
                  count_d = CNT_ONE;
                  state_d = READOUT;
               end
            end
            READOUT: begin
               if (READ_MODE) begin
                  sr_d    = {sr[WIDTH-3:0], 1'b0};
                  out_d   = sr[WIDTH-2];
                  count_d = count_inc;
                  if (count_inc == CNT_LAST) begin
                     done_d  = 1'b1;
                     state_d = DRAINED;
                  end
               end else begin
                  crc_d     = INIT;
                  count_d   = '0;
                  overrun_d = 1'b0;
                  out_d     = 1'b0;
                  state_d   = ACCUM;
               end
            end
            DRAINED: begin
               if (READ_MODE) begin
                  out_d     = 1'b0;
                  overrun_d = 1'b1;
               end else begin
                  crc_d     = INIT;
                  count_d   = '0;
                  overrun_d = 1'b0;
                  out_d     = 1'b0;
                  state_d   = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ACCUM;
         crc_reg    <= INIT;
         sr         <= '0;
         CRC_OUT    <= 1'b0;
         CRC_VALUE  <= '0;
         BIT_COUNT  <= '0;
         FRAME_DONE <= 1'b0;
         CRC_ZERO   <= 1'b0;
         OVERRUN    <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_reg    <= crc_d;
         sr         <= sr_d;
         CRC_OUT    <= out_d;
         CRC_VALUE  <= value_d;
         BIT_COUNT  <= count_d;
         FRAME_DONE <= done_d;
         CRC_ZERO   <= zero_d;
         OVERRUN    <= overrun_d;
      end
   end

endmodule
